// File: rtl/poly_mau_sequencer.sv
// poly_mau_sequencer: replays one latched POLY_MAU operation 1..15 times per start,
// generating the enable window, scope trigger, result capture and a sticky timeout.
module poly_mau_sequencer #(
   parameter int DW        = 24,
   parameter int EN_CYCLES = 6,
   parameter int MAX_WAIT  = 15,
   parameter int REP_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DW-1:0]    op_a,
   input  logic [DW-1:0]    op_b,
   input  logic [REP_W-1:0] rep_cnt,
   output logic [DW-1:0]    mau_a,
   output logic [DW-1:0]    mau_b,
   output logic             mau_enable,
   input  logic             mau_valid,
   input  logic [DW-1:0]    mau_o0,
   input  logic [DW-1:0]    mau_o1,
   output logic [DW-1:0]    res_o0,
   output logic [DW-1:0]    res_o1,
   output logic             trig,
   output logic             busy,
   output logic             done,
   output logic             timeout_err
);
   localparam int EW = $clog2(EN_CYCLES + 1);
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [EW-1:0] EN_LAST   = EW'(EN_CYCLES - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

   typedef enum logic [2:0] {IDLE, RUN, WAIT, GAP, DONE} state_t;

   state_t           state, state_n;
   logic [EW-1:0]    en_cnt, en_cnt_n;
   logic [WW-1:0]    wait_cnt, wait_cnt_n;
   logic [REP_W-1:0] ops_left, ops_n;
   logic             got, got_n, first_done, first_n, err_n, cap;
   logic [DW-1:0]    a_n, b_n;

   // Only the first valid of an operation is captured; WAIT is entered with got clear.
   assign cap = mau_valid && ((state == RUN && !got) || state == WAIT);

   always_comb begin
      state_n    = state;
      en_cnt_n   = en_cnt;
      wait_cnt_n = wait_cnt;
      ops_n      = ops_left;
      got_n      = got | cap;
      first_n    = first_done;
      err_n      = timeout_err;
      a_n        = mau_a;
      b_n        = mau_b;
      unique case (state)
         IDLE: if (start) begin
            a_n      = op_a;
            b_n      = op_b;
            ops_n    = rep_cnt == '0 ? REP_W'(1) : rep_cnt;
            err_n    = 1'b0;
            first_n  = 1'b0;
            got_n    = 1'b0;
            en_cnt_n = '0;
            state_n  = RUN;
         end
         RUN: if (en_cnt == EN_LAST) begin
            en_cnt_n   = '0;
            wait_cnt_n = '0;
            state_n    = (got || mau_valid) ? GAP : WAIT;
         end else
            en_cnt_n = en_cnt + 1'b1;
         WAIT: if (mau_valid)
            state_n = GAP;
         else begin
            wait_cnt_n = wait_cnt + 1'b1;
            if (wait_cnt == WAIT_LAST) begin
               err_n   = 1'b1;
               state_n = DONE;
            end
         end
         GAP: begin
            ops_n   = ops_left - 1'b1;
            got_n   = 1'b0;
            first_n = 1'b1;
            state_n = ops_left == REP_W'(1) ? DONE : RUN;
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         en_cnt      <= '0;
         wait_cnt    <= '0;
         ops_left    <= '0;
         got         <= 1'b0;
         first_done  <= 1'b0;
         mau_a       <= '0;
         mau_b       <= '0;
         res_o0      <= '0;
         res_o1      <= '0;
         mau_enable  <= 1'b0;
         trig        <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_n;
         en_cnt      <= en_cnt_n;
         wait_cnt    <= wait_cnt_n;
         ops_left    <= ops_n;
         got         <= got_n;
         first_done  <= first_n;
         mau_a       <= a_n;
         mau_b       <= b_n;
         res_o0      <= cap ? mau_o0 : res_o0;
         res_o1      <= cap ? mau_o1 : res_o1;
         mau_enable  <= state_n == RUN;
         trig        <= state_n == RUN && !first_n;
         busy        <= state_n != IDLE;
         done        <= state_n == DONE;
         timeout_err <= err_n;
      end
   end
endmodule

// File: tb/tb_poly_mau_sequencer.sv
// tb_poly_mau_sequencer: builds each run's expected cycle timeline from operation
// lengths, then drives it and compares every output on every cycle.
module tb_poly_mau_sequencer;
   localparam int DW = 24, EN = 6, MW = 15, NC = 512;

   logic clk = 0, rst = 1, start = 0, mau_valid = 0;
   logic [DW-1:0] op_a = 0, op_b = 0, mau_o0 = 0, mau_o1 = 0;
   logic [3:0] rep_cnt = 0;
   logic [DW-1:0] mau_a, mau_b, res_o0, res_o1;
   logic mau_enable, trig, busy, done, timeout_err;

   int tests = 0, failed = 0, cur = 0, run_len = 0;
   int obs_done = -1, en_obs = 0, trig_obs = 0;
   bit chk_on = 0;
   int kind[16], off[16];
   logic s_start[NC], s_valid[NC], s_rst[NC], cap[NC];
   logic [3:0] s_rep[NC];
   logic [DW-1:0] s_a[NC], s_b[NC], s_o0[NC], s_o1[NC];
   logic e_en[NC], e_trig[NC], e_busy[NC], e_done[NC], e_err[NC];
   logic [DW-1:0] e_a[NC], e_b[NC], e_r0[NC], e_r1[NC];
   logic [DW-1:0] m_a = 0, m_b = 0, m_r0 = 0, m_r1 = 0;
   logic m_err = 0;

   poly_mau_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .rep_cnt(rep_cnt),
      .mau_a(mau_a), .mau_b(mau_b), .mau_enable(mau_enable), .mau_valid(mau_valid),
      .mau_o0(mau_o0), .mau_o1(mau_o1), .res_o0(res_o0), .res_o1(res_o1),
      .trig(trig), .busy(busy), .done(done), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] want);
      tests++;
      if (act !== want) begin
         failed++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cur, act, want);
      end
   endtask

   always @(negedge clk) if (chk_on) begin
      if (cur == 0) begin
         obs_done = -1;
         en_obs   = 0;
         trig_obs = 0;
      end
      if (done === 1'b1 && obs_done < 0) obs_done = cur;
      if (mau_enable === 1'b1) en_obs++;
      if (trig === 1'b1) trig_obs++;
      chk("mau_enable", DW'(mau_enable), DW'(e_en[cur]));
      chk("trig", DW'(trig), DW'(e_trig[cur]));
      chk("busy", DW'(busy), DW'(e_busy[cur]));
      chk("done", DW'(done), DW'(e_done[cur]));
      chk("timeout_err", DW'(timeout_err), DW'(e_err[cur]));
      chk("mau_a", mau_a, e_a[cur]);
      chk("mau_b", mau_b, e_b[cur]);
      chk("res_o0", res_o0, e_r0[cur]);
      chk("res_o1", res_o1, e_r1[cur]);
   end

   // kind 0: valid off cycles into the window; 1: valid off cycles after it; 2: never.
   task automatic rand_kinds();
      for (int i = 0; i < 16; i++) begin
         int r = $urandom_range(0, 15);
         kind[i] = r < 2 ? 2 : r < 6 ? 1 : 0;
         off[i]  = kind[i] == 0 ? $urandom_range(0, EN - 1) : $urandom_range(1, MW);
      end
   endtask

   // rst_at: -1 none, -2 random cycle before done, otherwise the cycle rst is high.
   task automatic build(input int rep, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                        input logic [DW-1:0] o0, input int rst_at, input bit noise);
      int n, t, vc, gap, dc, ra;
      bit to;
      logic [DW-1:0] r0, r1;
      for (int c = 0; c < NC; c++) begin
         s_start[c] = 0; s_valid[c] = 0; s_rst[c] = 0; cap[c] = 0;
         s_rep[c] = 4'($urandom); s_a[c] = DW'($urandom); s_b[c] = DW'($urandom);
         s_o0[c] = DW'($urandom); s_o1[c] = DW'($urandom);
         e_en[c] = 0; e_trig[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_err[c] = 0;
         e_a[c] = 0; e_b[c] = 0; e_r0[c] = 0; e_r1[c] = 0;
      end
      s_start[0] = 1; s_rep[0] = 4'(rep); s_a[0] = a0; s_b[0] = b0;
      n = rep == 0 ? 1 : rep;
      t = 1; to = 0; dc = 0;
      for (int i = 0; i < n && !to; i++) begin
         for (int c = t; c < t + EN; c++) begin
            e_en[c] = 1;
            e_trig[c] = i == 0;
         end
         if (kind[i] == 2) begin
            to = 1;
            dc = t + EN + MW;
         end else begin
            vc  = kind[i] == 0 ? t + off[i] : t + EN + off[i] - 1;
            gap = kind[i] == 0 ? t + EN : t + EN + off[i];
            s_valid[vc] = 1; cap[vc] = 1;
            if (i == 0) s_o0[vc] = o0;
            if (noise && kind[i] == 0 && vc + 1 < t + EN && $urandom_range(0, 1) == 1)
               s_valid[$urandom_range(vc + 1, t + EN - 1)] = 1;
            if (noise && $urandom_range(0, 1) == 1) s_valid[gap] = 1;
            t = gap + 1;
         end
      end
      if (!to) dc = t;
      if (noise) begin
         s_valid[dc] = 1;
         s_start[$urandom_range(1, dc)] = 1;
         s_start[dc] = 1;
      end
      run_len = dc + 1 + $urandom_range(0, 3);
      r0 = m_r0; r1 = m_r1;
      for (int c = 0; c < run_len; c++) begin
         e_busy[c] = c >= 1 && c <= dc;
         e_done[c] = c == dc;
         e_err[c]  = c == 0 ? m_err : c < dc ? 1'b0 : to;
         e_a[c]    = c == 0 ? m_a : a0;
         e_b[c]    = c == 0 ? m_b : b0;
         e_r0[c]   = r0;
         e_r1[c]   = r1;
         if (cap[c]) begin
            r0 = s_o0[c];
            r1 = s_o1[c];
         end
      end
      ra = rst_at == -2 ? $urandom_range(0, dc - 1) : rst_at;
      if (ra >= 0) begin
         s_rst[ra] = 1; s_start[ra] = 1;
         for (int c = ra + 1; c < NC; c++) s_start[c] = 0;
         run_len = ra + 2;
         e_en[ra+1] = 0; e_trig[ra+1] = 0; e_busy[ra+1] = 0; e_done[ra+1] = 0; e_err[ra+1] = 0;
         e_a[ra+1] = 0; e_b[ra+1] = 0; e_r0[ra+1] = 0; e_r1[ra+1] = 0;
      end
      m_a = e_a[run_len-1]; m_b = e_b[run_len-1];
      m_r0 = e_r0[run_len-1]; m_r1 = e_r1[run_len-1]; m_err = e_err[run_len-1];
   endtask

   task automatic run();
      for (int c = 0; c < run_len; c++) begin
         @(posedge clk);
         #1;
         cur = c; chk_on = 1;
         rst = s_rst[c]; start = s_start[c]; rep_cnt = s_rep[c];
         op_a = s_a[c]; op_b = s_b[c];
         mau_valid = s_valid[c]; mau_o0 = s_o0[c]; mau_o1 = s_o1[c];
      end
      @(negedge clk);
      #1;
   endtask

   task automatic single(input int k, input int o, input logic [DW-1:0] a0);
      kind[0] = k; off[0] = o;
      build(1, a0, DW'($urandom), DW'($urandom), -1, 0);
   endtask

   initial begin
      rst = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_enable", DW'(mau_enable), '0);
      chk("rst_busy", DW'(busy), '0);
      chk("rst_done", DW'(done), '0);
      chk("rst_err", DW'(timeout_err), '0);
      chk("rst_a", mau_a, '0);
      chk("rst_r0", res_o0, '0);

      kind[0] = 0; off[0] = 3;
      build(1, 24'h000123, 24'h000456, 24'hABCDEF, -1, 0);
      run();
      chk("single_done_cycle", DW'(obs_done), DW'(8));
      chk("single_en_cycles", DW'(en_obs), DW'(6));
      chk("single_trig_cycles", DW'(trig_obs), DW'(6));
      chk("single_res_o0", res_o0, 24'hABCDEF);
      chk("single_mau_b", mau_b, 24'h000456);
      chk("single_err", DW'(timeout_err), '0);

      for (int i = 0; i < 3; i++) begin kind[i] = 0; off[i] = $urandom_range(0, EN - 1); end
      build(3, DW'($urandom), DW'($urandom), DW'($urandom), -1, 0);
      run();
      chk("rep3_done_cycle", DW'(obs_done), DW'(22));
      chk("rep3_en_cycles", DW'(en_obs), DW'(18));
      chk("rep3_trig_cycles", DW'(trig_obs), DW'(6));

      single(1, 3, DW'($urandom));
      run();
      chk("late3_done_cycle", DW'(obs_done), DW'(11));

      kind[0] = 2;
      build(3, DW'($urandom), DW'($urandom), DW'($urandom), -1, 0);
      run();
      chk("timeout_done_cycle", DW'(obs_done), DW'(22));
      chk("timeout_en_cycles", DW'(en_obs), DW'(6));
      chk("timeout_err_set", DW'(timeout_err), DW'(1));

      single(0, 2, DW'($urandom));
      run();
      chk("err_cleared", DW'(timeout_err), '0);

      single(0, 1, 24'h00BEEF);
      s_start[3] = 1; s_start[8] = 1; s_a[3] = 24'h111111; s_a[8] = 24'h222222;
      run();
      chk("busy_ign_done_cycle", DW'(obs_done), DW'(8));
      chk("busy_ign_mau_a", mau_a, 24'h00BEEF);

      kind[0] = 0; off[0] = 4;
      build(0, DW'($urandom), DW'($urandom), DW'($urandom), -1, 0);
      run();
      chk("rep0_done_cycle", DW'(obs_done), DW'(8));
      chk("rep0_en_cycles", DW'(en_obs), DW'(6));

      kind[0] = 0; off[0] = 1;
      build(1, DW'($urandom), DW'($urandom), DW'($urandom), 4, 0);
      run();
      chk("rst_mid_no_done", DW'(obs_done), DW'(-1));
      chk("rst_mid_busy", DW'(busy), '0);

      single(0, 5, DW'($urandom));
      run();
      chk("after_rst_done_cycle", DW'(obs_done), DW'(8));

      for (int r = 0; r < 60; r++) begin
         rand_kinds();
         build($urandom_range(0, 15), DW'($urandom), DW'($urandom), DW'($urandom),
               $urandom_range(0, 9) == 0 ? -2 : -1, 1);
         run();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
